// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite command master (optional watchdog: AXIL_MASTER_TIMEOUT_EN)
module axil_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    // command side
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    // response side
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                busy,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // AXI4-Lite write response
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_READ  = 3'd3,
        S_RDATA = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    // The watchdog needs at least one cycle of headroom before it can fire.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    state_t              state, state_n;
    logic [ADDR_W-1:0]   awaddr_n, araddr_n;
    logic [DATA_W-1:0]   wdata_n, rsp_rdata_n;
    logic [DATA_W/8-1:0] wstrb_n;
    logic                awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic                rsp_write_n;
    logic [1:0]          rsp_resp_n;

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RSP);
    assign busy      = (state != S_IDLE);

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             any_hs;
    logic             in_xfer;

    assign in_xfer = (state == S_WRITE) || (state == S_WRESP) ||
                     (state == S_READ)  || (state == S_RDATA);
    assign any_hs  = (awvalid && awready) || (wvalid && wready) ||
                     (bvalid && bready)   || (arvalid && arready) ||
                     (rvalid && rready);

    // Watchdog: cleared while idle, counts whole-transaction cycles, saturates at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (!in_xfer) begin
            to_cnt <= '0;
        end else if (to_cnt < TO_LIMIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_n     = state;
        awaddr_n    = awaddr;
        wdata_n     = wdata;
        wstrb_n     = wstrb;
        araddr_n    = araddr;
        awvalid_n   = awvalid;
        wvalid_n    = wvalid;
        bready_n    = bready;
        arvalid_n   = arvalid;
        rready_n    = rready;
        rsp_rdata_n = rsp_rdata;
        rsp_resp_n  = rsp_resp;
        rsp_write_n = rsp_write;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_n  = cmd_addr;
                        wdata_n   = cmd_wdata;
                        wstrb_n   = cmd_wstrb;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        state_n   = S_WRITE;
                    end else begin
                        araddr_n  = cmd_addr;
                        arvalid_n = 1'b1;
                        state_n   = S_READ;
                    end
                end
            end
            S_WRITE: begin
                // Address and data channels retire independently, in any order.
                if (awvalid && awready) awvalid_n = 1'b0;
                if (wvalid && wready)   wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid && bready) begin
                    bready_n    = 1'b0;
                    rsp_resp_n  = bresp;
                    rsp_rdata_n = '0;
                    rsp_write_n = 1'b1;
                    state_n     = S_RSP;
                end
            end
            S_READ: begin
                if (arvalid && arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid && rready) begin
                    rready_n    = 1'b0;
                    rsp_rdata_n = rdata;
                    rsp_resp_n  = rresp;
                    rsp_write_n = 1'b0;
                    state_n     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
        // A handshake on the expiry edge takes priority over the timeout.
        if (in_xfer && (to_cnt == TO_LIMIT) && !any_hs) begin
            awvalid_n   = 1'b0;
            wvalid_n    = 1'b0;
            bready_n    = 1'b0;
            arvalid_n   = 1'b0;
            rready_n    = 1'b0;
            rsp_resp_n  = 2'b11;
            rsp_rdata_n = '0;
            rsp_write_n = (state == S_WRITE) || (state == S_WRESP);
            state_n     = S_RSP;
        end
`endif
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            awaddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            araddr    <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            rsp_write <= 1'b0;
        end else begin
            state     <= state_n;
            awaddr    <= awaddr_n;
            wdata     <= wdata_n;
            wstrb     <= wstrb_n;
            araddr    <= araddr_n;
            awvalid   <= awvalid_n;
            wvalid    <= wvalid_n;
            bready    <= bready_n;
            arvalid   <= arvalid_n;
            rready    <= rready_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_resp  <= rsp_resp_n;
            rsp_write <= rsp_write_n;
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed self-checking bench for axil_cmd_master
module tb_axil_cmd_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_wstrb;
    logic                rsp_valid, rsp_ready, rsp_write;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [1:0]          rsp_resp;
    logic                busy;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    logic                arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [1:0]          bresp, rresp;

    int checks   = 0;
    int failures = 0;

    axil_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        chk("cmd_ready_at_issue", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0;
        tick(); tick();

        // reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
        chk("rst_payload", {awaddr, wdata, wstrb, araddr}, 100'h0);
        rst = 1'b0;
        tick();

        // write with always-ready slave
        awready = 1; wready = 1; arready = 1;
        issue(1'b1, 32'h4, 32'hA5A5_1234, 4'hF);
        chk("wr_valids", {awvalid, wvalid, bready}, 3'b110);
        chk("wr_awaddr", awaddr, 32'h4);
        chk("wr_wdata", wdata, 32'hA5A5_1234);
        chk("wr_wstrb", wstrb, 4'hF);
        chk("wr_busy", {busy, cmd_ready}, 2'b10);
        tick();
        chk("wr_bready", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
        chk("wr_bready_off", bready, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("wr_done", {rsp_valid, cmd_ready}, 2'b01);

        // read-back, 3-cycle accept-to-response
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("rd_arvalid", {arvalid, rready}, 2'b10);
        chk("rd_araddr", araddr, 32'h4);
        tick();
        chk("rd_rready", {arvalid, rready, rsp_valid}, 3'b010);
        rvalid = 1; rdata = 32'hA5A5_1234; rresp = 2'b00;
        tick();
        rvalid = 0;
        chk("rd_lat3_rsp_valid", rsp_valid, 1);
        chk("rd_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'hA5A5_1234});
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rd_done", cmd_ready, 1);

        // split handshakes: data accepted 3 cycles before address
        awready = 0; wready = 1;
        issue(1'b1, 32'h8, 32'h1122_3344, 4'h3);
        chk("sp_both_valid", {awvalid, wvalid}, 2'b11);
        tick();
        wready = 0;
        for (int i = 0; i < 3; i++) begin
            chk("sp_w_first", {awvalid, wvalid, bready}, 3'b100);
            chk("sp_awaddr_stable", awaddr, 32'h8);
            if (i == 2) awready = 1;
            tick();
        end
        awready = 0;
        chk("sp_bready", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = 2'b10;
        tick();
        bvalid = 0;
        chk("sp_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b10, 32'h0});
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // read SLVERR with response backpressure; stray rvalid while in READ is ignored
        arready = 1;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        rvalid = 1; rdata = 32'h0BAD_0BAD; rresp = 2'b00;
        chk("err_araddr", araddr, 32'h10);
        tick();
        rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        chk("err_rready", rready, 1);
        tick();
        rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("err_hold_valid", {rsp_valid, cmd_ready}, 2'b10);
            chk("err_hold_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'hDEAD_BEEF});
            tick();
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("err_done", {rsp_valid, cmd_ready}, 2'b01);

        // reset mid-transaction
        awready = 0; wready = 0; arready = 0;
        issue(1'b1, 32'h20, 32'h5555_AAAA, 4'hF);
        chk("mr_awvalid", awvalid, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mr_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("mr_idle", {cmd_ready, busy}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_rsp", rsp_valid, 0);
            tick();
        end

`ifdef AXIL_MASTER_TIMEOUT_EN
        // timeout: arready stuck low, TIMEOUT_CYCLES = 8
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            chk("to_arvalid_held", {arvalid, rsp_valid}, 2'b10);
            tick();
        end
        chk("to_arvalid_drop", arvalid, 0);
        chk("to_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b11, 32'h0});
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("to_done", cmd_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
